// File: rtl/bist_pkg.sv
// Shared BIST definitions: generator FSM states and the Galois LFSR tap table.
// The tap table is common to the pattern generator and the response MISR. Both sides
// must agree on it for signatures to be reproducible.
package bist_pkg;

    // Pattern generator control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_e;

    localparam int unsigned LFSR_MIN_W = 2;
    localparam int unsigned LFSR_MAX_W = 32;

    // Maximal-length Galois tap table, indexed by register width.
    // Each entry is the primitive polynomial shifted right by one (the x^0 term is implicit).
    // Bit k-1 set means the x^k term is present, so tap[i-1] feeds stage i.
    // Example: width 8 uses x^8+x^4+x^3+x^2+1, which gives entry 8'h8E.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            1:       taps = 32'h0000_0001;
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_008E;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_8016;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h0080_0043;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/bist_prbs_gen_if.sv
// Pattern stream between the BIST generator and its consumer.
// Simple valid/ready handshake; a pattern transfers on any cycle with valid & ready.
interface bist_prbs_gen_if #(
    parameter int unsigned DATA_DW = 8
) ();

    logic [DATA_DW-1:0] data;
    logic               valid;
    logic               ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/bist_prbs_lfsr.sv
// Galois LFSR register with load and step enables.
// The same block serves the response side: din is XORed into the step, so the
// generator ties din to zero and a MISR feeds its response word.
// A zero load value is replaced by all-ones, because the all-zero state is a lock-up state.
module bist_prbs_lfsr
    import bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8  // legal 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] state
);

    localparam logic [31:0]      TAP_WORD = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP_WORD[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_val;

    // One Galois shift: the MSB wraps to bit 0 and is XORed into each tapped stage
    always_comb begin
        step_val    = '0;
        step_val[0] = state_q[WIDTH-1] ^ din[0];
        for (int i = 1; i < int'(WIDTH); i++) begin
            step_val[i] = state_q[i-1] ^ (TAPS[i-1] & state_q[WIDTH-1]) ^ din[i];
        end
    end

    // Next-state select: a load has priority over a step
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? '1 : load_val;
        end else if (step) begin
            state_d = step_val;
        end
    end

    // State register, reset to all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/bist_prbs_gen.sv
// BIST pseudo-random pattern generator.
// The BIST sequencer starts a run with a seed and a pattern count. The generator then
// emits LFSR patterns on a valid/ready stream, and pulses gen_done when every pattern
// has been accepted. gen_abort returns the generator to IDLE at once without a done pulse.
// Optional macro BIST_PRBS_ERR_INJECT_EN adds the gen_err_inject port. It inverts bit 0
// of the next accepted pattern and leaves the LFSR sequence unaffected.
module bist_prbs_gen
    import bist_pkg::*;
#(
    parameter int unsigned LFSR_DW = 8,   // legal 2..32
    parameter int unsigned DATA_DW = 8,   // 1..LFSR_DW
    parameter int unsigned CNT_W   = 16
) (
    input  logic               func_clk,
    input  logic               func_rst_n,
    input  logic               gen_start,
    input  logic               gen_abort,
    input  logic [LFSR_DW-1:0] gen_seed,
    input  logic [CNT_W-1:0]   gen_num_patterns,
`ifdef BIST_PRBS_ERR_INJECT_EN
    input  logic               gen_err_inject,
`endif
    output logic               gen_busy,
    output logic               gen_done,
    output logic [CNT_W-1:0]   gen_pattern_cnt,
    bist_prbs_gen_if.master    gen_stream
);

    bist_state_e        state_q, state_d;
    logic [LFSR_DW-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lfsr_load;
    logic               lfsr_step;
    logic [LFSR_DW-1:0] lfsr_state;

    // Next-state, run parameter capture and LFSR control
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Abort wins over a simultaneous start
                if (gen_start && !gen_abort) begin
                    state_d = LOAD;
                    seed_d  = gen_seed;
                    num_d   = gen_num_patterns;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (gen_abort) begin
                    state_d = IDLE;
                end else begin
                    lfsr_load = 1'b1;
                    state_d   = (num_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort takes priority, so a same-cycle handshake is not counted
                if (gen_abort) begin
                    state_d = IDLE;
                end else if (gen_stream.ready) begin
                    lfsr_step = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == num_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and run registers
    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            state_q <= IDLE;
            seed_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
        end
    end

    bist_prbs_lfsr #(
        .WIDTH (LFSR_DW)
    ) u_lfsr (
        .clk      (func_clk),
        .rst_n    (func_rst_n),
        .load     (lfsr_load),
        .load_val (seed_q),
        .step     (lfsr_step),
        .din      ({LFSR_DW{1'b0}}),
        .state    (lfsr_state)
    );

    assign gen_busy         = (state_q != IDLE);
    assign gen_done         = (state_q == DONE);
    assign gen_pattern_cnt  = cnt_q;
    assign gen_stream.valid = (state_q == RUN);

`ifdef BIST_PRBS_ERR_INJECT_EN
    logic inj_q, inj_d;

    // Sticky inject request: consumed by the next accepted pattern, cleared by abort
    always_comb begin
        inj_d = inj_q;
        if (gen_abort) begin
            inj_d = 1'b0;
        end else begin
            if (gen_stream.valid && gen_stream.ready) begin
                inj_d = 1'b0;
            end
            if (gen_err_inject) begin
                inj_d = 1'b1;
            end
        end
    end

    // Inject flag register
    always_ff @(posedge func_clk or negedge func_rst_n) begin
        if (!func_rst_n) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end

    assign gen_stream.data = lfsr_state[DATA_DW-1:0] ^ DATA_DW'(inj_q);
`else
    assign gen_stream.data = lfsr_state[DATA_DW-1:0];
`endif

endmodule

// File: tb/tb_bist_prbs_gen.sv
// Self-checking bench for bist_prbs_gen (LFSR_DW = DATA_DW = 8, CNT_W = 16).
// The reference model steps the pattern as polynomial multiplication by x modulo
// x^8+x^4+x^3+x^2+1 and tracks the run at the transaction level.
// Honours BIST_PRBS_ERR_INJECT_EN like the design does.
module tb_bist_prbs_gen;

    localparam logic [8:0] POLY = 9'h11D;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  seed;
    logic [15:0] num;
    logic        inject;
    logic        busy;
    logic        done;
    logic [15:0] cnt;

    bist_prbs_gen_if #(.DATA_DW(8)) gen_if ();

    bist_prbs_gen #(
        .LFSR_DW (8),
        .DATA_DW (8),
        .CNT_W   (16)
    ) dut (
        .func_clk         (clk),
        .func_rst_n       (rst_n),
        .gen_start        (start),
        .gen_abort        (abort),
        .gen_seed         (seed),
        .gen_num_patterns (num),
`ifdef BIST_PRBS_ERR_INJECT_EN
        .gen_err_inject   (inject),
`endif
        .gen_busy         (busy),
        .gen_done         (done),
        .gen_pattern_cnt  (cnt),
        .gen_stream       (gen_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit sim_done = 0;

    logic [7:0] hs_q[$];    // data of every accepted pattern in the current run
    logic [7:0] vcyc_q[$];  // data on every valid cycle in the current run
    int         done_cnt;
    int         busy_cyc;

    // Multiply by x modulo the generator polynomial
    function automatic logic [7:0] mul_x(input logic [7:0] v);
        logic [8:0] t;
        t = {v, 1'b0};
        if (t[8]) t = t ^ POLY;
        return t[7:0];
    endfunction

    // Reference model: expected status/data for the coming cycle
    logic        m_busy, m_load, m_valid, m_done, m_flag;
    logic [7:0]  m_lfsr, m_seed;
    logic [15:0] m_cnt, m_num;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_load  <= 1'b0;
            m_valid <= 1'b0;
            m_done  <= 1'b0;
            m_flag  <= 1'b0;
            m_lfsr  <= 8'hFF;
            m_seed  <= 8'h00;
            m_cnt   <= 16'd0;
            m_num   <= 16'd0;
        end else begin
            if (!m_busy) begin
                if (start && !abort) begin
                    m_busy <= 1'b1;
                    m_load <= 1'b1;
                    m_cnt  <= 16'd0;
                    m_seed <= seed;
                    m_num  <= num;
                end
            end else if (abort) begin
                m_busy  <= 1'b0;
                m_load  <= 1'b0;
                m_valid <= 1'b0;
                m_done  <= 1'b0;
            end else if (m_load) begin
                m_load <= 1'b0;
                m_lfsr <= (m_seed == 8'h00) ? 8'hFF : m_seed;
                if (m_num == 16'd0) m_done <= 1'b1;
                else                m_valid <= 1'b1;
            end else if (m_done) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end else if (m_valid && gen_if.ready) begin
                m_lfsr <= mul_x(m_lfsr);
                m_cnt  <= m_cnt + 16'd1;
                if (int'(m_cnt) + 1 == int'(m_num)) begin
                    m_valid <= 1'b0;
                    m_done  <= 1'b1;
                end
            end
`ifdef BIST_PRBS_ERR_INJECT_EN
            if (abort) m_flag <= 1'b0;
            else       m_flag <= (m_flag && !(m_valid && gen_if.ready)) || inject;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_run(input logic [7:0] s, input logic [15:0] n, input int rmode,
                          input int abort_after, input bit noise);
        int vseen;
        bit ended;
        hs_q.delete();
        vcyc_q.delete();
        done_cnt = 0;
        busy_cyc = 0;
        vseen    = 0;
        ended    = 0;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        num   = n;
        abort = 1'b0;
        gen_if.ready = (rmode == 0);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start  = 1'b0;
            abort  = 1'b0;
            inject = 1'b0;
            if (!busy) begin
                ended = 1;
                break;
            end
            case (rmode)
                0:       gen_if.ready = 1'b1;
                1:       gen_if.ready = ($urandom % 4) != 0;
                default: begin
                    if (gen_if.valid) vseen++;
                    gen_if.ready = (vseen > 3);
                end
            endcase
            if (abort_after >= 0 && hs_q.size() == abort_after && gen_if.valid) begin
                abort = 1'b1;
                gen_if.ready = 1'b1;
            end
            if (noise) begin
                if (busy && !done && ($urandom % 8) == 0) begin
                    start = 1'b1;
                    seed  = 8'($urandom);
                    num   = 16'($urandom);
                end
                if (($urandom % 50) == 0) abort = 1'b1;
`ifdef BIST_PRBS_ERR_INJECT_EN
                inject = ($urandom % 8) == 0;
`endif
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (!ended) chk("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] exp2 [6];
        exp2 = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04};
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed = 8'h00;
        num = 16'd0;
        inject = 1'b0;
        gen_if.ready = 1'b0;
        fork
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                chk("reset_busy", 32'(busy), 32'd0);
                chk("reset_valid", 32'(gen_if.valid), 32'd0);
                chk("reset_done", 32'(done), 32'd0);
                chk("reset_cnt", 32'(cnt), 32'd0);
                chk("reset_data", 32'(gen_if.data), 32'hFF);
                rst_n = 1'b1;

                // Seed 80, two patterns, ready high
                do_run(8'h80, 16'd2, 0, -1, 0);
                chk("t1_hs_n", 32'(hs_q.size()), 32'd2);
                chk("t1_hs0", 32'(hs_q[0]), 32'h80);
                chk("t1_hs1", 32'(hs_q[1]), 32'h1D);
                chk("t1_done", 32'(done_cnt), 32'd1);
                chk("t1_cnt", 32'(cnt), 32'd2);

                // Backpressure holds the first pattern for four cycles
                do_run(8'h01, 16'd3, 2, -1, 0);
                chk("t2_vcyc_n", 32'(vcyc_q.size()), 32'd6);
                for (int i = 0; i < 6; i++) chk("t2_vcyc", 32'(vcyc_q[i]), 32'(exp2[i]));
                chk("t2_done", 32'(done_cnt), 32'd1);
                chk("t2_cnt", 32'(cnt), 32'd3);

                // Zero seed falls back to all-ones
                do_run(8'h00, 16'd1, 0, -1, 0);
                chk("t3_hs_n", 32'(hs_q.size()), 32'd1);
                chk("t3_hs0", 32'(hs_q[0]), 32'hFF);
                chk("t3_done", 32'(done_cnt), 32'd1);
                chk("t3_cnt", 32'(cnt), 32'd1);

                // Zero patterns: no valid, busy for LOAD and DONE
                do_run(8'h5A, 16'd0, 0, -1, 0);
                chk("t4_vcyc_n", 32'(vcyc_q.size()), 32'd0);
                chk("t4_done", 32'(done_cnt), 32'd1);
                chk("t4_busy_cyc", 32'(busy_cyc), 32'd2);
                chk("t4_cnt", 32'(cnt), 32'd0);

                // Abort coincident with the 11th handshake
                do_run(8'h80, 16'd100, 0, 10, 0);
                chk("t5_hs_n", 32'(hs_q.size()), 32'd10);
                chk("t5_done", 32'(done_cnt), 32'd0);
                chk("t5_cnt", 32'(cnt), 32'd10);
                chk("t5_busy", 32'(busy), 32'd0);
                do_run(8'h80, 16'd2, 0, -1, 0);
                chk("t5_restart_hs1", 32'(hs_q[1]), 32'h1D);
                chk("t5_restart_cnt", 32'(cnt), 32'd2);

                // Start and abort together in IDLE
                @(posedge clk); #1;
                start = 1'b1;
                abort = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                chk("start_abort_idle", 32'(busy), 32'd0);

`ifdef BIST_PRBS_ERR_INJECT_EN
                @(posedge clk); #1;
                inject = 1'b1;
                @(posedge clk); #1;
                inject = 1'b0;
                do_run(8'h80, 16'd2, 0, -1, 0);
                chk("t6_hs0", 32'(hs_q[0]), 32'h81);
                chk("t6_hs1", 32'(hs_q[1]), 32'h1D);
`endif

                // Asynchronous reset in the middle of a run
                @(posedge clk); #1;
                start = 1'b1;
                seed = 8'h55;
                num = 16'd50;
                gen_if.ready = 1'b1;
                repeat (5) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                end
                rst_n = 1'b0;
                #1;
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_valid", 32'(gen_if.valid), 32'd0);
                chk("mid_rst_cnt", 32'(cnt), 32'd0);
                chk("mid_rst_data", 32'(gen_if.data), 32'hFF);
                @(posedge clk); #1;
                rst_n = 1'b1;

                // Randomised runs against the model
                for (int r = 0; r < 60; r++) begin
                    do_run(8'($urandom), 16'($urandom_range(0, 20)), 1, -1, 1);
                end

                repeat (2) @(posedge clk);
                sim_done = 1;
            end
            begin : compare
                while (!sim_done) begin
                    @(negedge clk);
                    if (rst_n) begin
                        chk("busy", 32'(busy), 32'(m_busy));
                        chk("valid", 32'(gen_if.valid), 32'(m_valid));
                        chk("done", 32'(done), 32'(m_done));
                        chk("cnt", 32'(cnt), 32'(m_cnt));
                        if (m_valid) chk("data", 32'(gen_if.data), 32'(m_lfsr ^ {7'd0, m_flag}));
                        if (gen_if.valid) vcyc_q.push_back(gen_if.data);
                        if (gen_if.valid && gen_if.ready && !abort) hs_q.push_back(gen_if.data);
                        if (done) done_cnt++;
                        if (busy) busy_cyc++;
                    end
                end
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
